rr_index_arbiter: RTL and testbench

- Round-robin arbiter over 32 request lines.
- Emits the winning requester as a binary 5-bit index with a valid/ready handshake.
- Sits directly upstream of the 5-to-32 one-hot decoder. The decoder turns the index into the one-hot grant or select bus.
- Owns fairness state (rotating pointer) and holds each grant stable until the consumer accepts it.

---
 rtl/rr_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 28 ++
 rtl/rr_index_arbiter.sv | 72 +++++++
 tb/tb_rr_index_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared constants and types for the 32-way round-robin index arbiter.
// Widths are tied to the downstream 5-to-32 one-hot decoder.
package rr_arb_pkg;

    localparam int N_REQ = 32;
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner select: lowest set bit at or above ptr, else wrap to lowest set bit.
// Zero latency; no flow control.
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  idx_t             ptr,
    output logic             found,
    output idx_t             idx
);

    localparam logic [N_REQ-1:0] ALL_ONES = '1;

    logic [N_REQ-1:0] masked;
    logic [N_REQ-1:0] sel;

    always_comb begin
        masked = req & (ALL_ONES << ptr);
        sel    = (|masked) ? masked : req;
        found  = |req;
        idx    = '0;
        // Scan downward so the lowest set bit is the final assignment.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (sel[i]) idx = idx_t'(i);
        end
    end

endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter emitting a binary winner index; 1 cycle req-to-valid, one grant per cycle when streaming.
// Grant held stable while idx_valid && !idx_ready; req changes are ignored until accepted.
module rr_index_arbiter
    import rr_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic             idx_valid,
    input  logic             idx_ready,
    output idx_t             idx,
    output logic [CNT_W-1:0] grant_cnt
);

    state_t state;
    state_t state_nxt;
    idx_t   ptr;
    idx_t   idx_inc;
    idx_t   pick_ptr;
    idx_t   pick_idx;
    logic   pick_found;
    logic   handshake;
    logic   load;

    assign idx_inc   = idx_t'(idx + 1'b1);
    assign handshake = (state == HOLD) && idx_ready;

    // On a handshake the next pick must already see the advanced pointer.
    assign pick_ptr  = (state == HOLD) ? idx_inc : ptr;
    assign load      = en && pick_found && ((state == IDLE) || handshake);

    rr_pick u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = HOLD;
            HOLD:    if (idx_ready && !load) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        idx_valid = (state == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            ptr       <= '0;
            grant_cnt <= '0;
        end else begin
            if (load) idx <= pick_idx;
            if (handshake) begin
                ptr <= idx_inc;
                if (grant_cnt != '1) grant_cnt <= grant_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Scoreboard bench for rr_index_arbiter: a behavioural model pushes the expected
// {idx_valid, idx, grant_cnt} for each driven cycle, and each test pops and compares.
module tb_rr_index_arbiter;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] req;
    logic        idx_valid;
    logic        idx_ready;
    logic [4:0]  idx;
    logic [15:0] grant_cnt;

    int vectors;
    int miscompares;

    // Reference model state
    logic        m_valid;
    logic [4:0]  m_idx;
    logic [4:0]  m_ptr;
    logic [15:0] m_cnt;

    logic [21:0] sb[$];

    rr_index_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .idx       (idx),
        .grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, miscompares=%0d", miscompares);
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] ref_pick(input logic [31:0] r, input logic [4:0] p);
        logic [4:0] w;
        w = 5'd0;
        for (int k = 31; k >= 0; k--) begin
            if (r[(int'(p) + k) % 32]) w = 5'((int'(p) + k) % 32);
        end
        return w;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 5'd0;
        m_ptr   = 5'd0;
        m_cnt   = 16'd0;
        sb.delete();
    endtask

    task automatic model_step(input logic e, input logic [31:0] r, input logic rdy);
        if (m_valid && rdy) begin
            m_ptr = m_idx + 5'd1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (e && (r != 32'd0)) m_idx = ref_pick(r, m_ptr);
            else                   m_valid = 1'b0;
        end else if (!m_valid && e && (r != 32'd0)) begin
            m_idx   = ref_pick(r, m_ptr);
            m_valid = 1'b1;
        end
    endtask

    // Drives one cycle, records the expectation, returns at posedge+1.
    task automatic apply(input logic e, input logic [31:0] r, input logic rdy);
        en        = e;
        req       = r;
        idx_ready = rdy;
        model_step(e, r, rdy);
        sb.push_back({m_valid, m_idx, m_cnt});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        req       = 32'd0;
        idx_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({idx_valid, idx, grant_cnt} !== 22'd0) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b idx=%0d cnt=%0d, want all 0", idx_valid, idx, grant_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            logic [21:0] exp;
            apply(1'b1, 32'd0, 1'b1);
            exp = sb.pop_front();
            vectors++;
            if ({idx_valid, idx, grant_cnt} !== exp) begin
                miscompares++;
                $display("FAIL idle_no_req: got %h want %h", {idx_valid, idx, grant_cnt}, exp);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            logic [21:0] exp;
            apply(1'b1, 32'h0000_0001, 1'b1);
            exp = sb.pop_front();
            vectors++;
            if ({idx_valid, idx, grant_cnt} !== exp || idx !== 5'd0 || grant_cnt !== 16'(i)) begin
                miscompares++;
                $display("FAIL single_req cyc%0d: got valid=%b idx=%0d cnt=%0d want %h (cnt %0d)",
                         i, idx_valid, idx, grant_cnt, exp, i);
            end
        end
    endtask

    task automatic test_wrap();
        logic [4:0] seq [6];
        seq = '{5'd0, 5'd4, 5'd31, 5'd0, 5'd4, 5'd31};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            logic [21:0] exp;
            apply(1'b1, 32'h8000_0011, 1'b1);
            exp = sb.pop_front();
            vectors++;
            if ({idx_valid, idx, grant_cnt} !== exp || idx_valid !== 1'b1 || idx !== seq[i]) begin
                miscompares++;
                $display("FAIL wrap_seq cyc%0d: got valid=%b idx=%0d want idx=%0d (sb %h)",
                         i, idx_valid, idx, seq[i], exp);
            end
        end
    endtask

    task automatic test_hold();
        logic [21:0] exp;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 32'h0000_0006, 1'b0);
            exp = sb.pop_front();
            vectors++;
            if ({idx_valid, idx, grant_cnt} !== exp || idx !== 5'd1) begin
                miscompares++;
                $display("FAIL hold_stable cyc%0d: got valid=%b idx=%0d want %h", i, idx_valid, idx, exp);
            end
        end
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 32'h0000_0008, 1'b0);
            exp = sb.pop_front();
            vectors++;
            if ({idx_valid, idx, grant_cnt} !== exp || idx !== 5'd1) begin
                miscompares++;
                $display("FAIL hold_req_change: got valid=%b idx=%0d want idx=1", idx_valid, idx);
            end
        end
        apply(1'b1, 32'h0000_0008, 1'b1);
        exp = sb.pop_front();
        vectors++;
        if ({idx_valid, idx, grant_cnt} !== exp || idx !== 5'd3 || grant_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL hold_release: got valid=%b idx=%0d cnt=%0d want idx=3 cnt=1", idx_valid, idx, grant_cnt);
        end
    endtask

    task automatic test_en_drop();
        logic [21:0] exp;
        do_reset();
        apply(1'b1, 32'h0000_0004, 1'b0);
        exp = sb.pop_front();
        vectors++;
        if ({idx_valid, idx, grant_cnt} !== exp || idx !== 5'd2) begin
            miscompares++;
            $display("FAIL en_setup: got idx=%0d want 2", idx);
        end
        apply(1'b0, 32'h0000_0004, 1'b0);
        exp = sb.pop_front();
        vectors++;
        if ({idx_valid, idx, grant_cnt} !== exp || idx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL en_drop_keep: got valid=%b want 1", idx_valid);
        end
        apply(1'b0, 32'h0000_0004, 1'b1);
        exp = sb.pop_front();
        vectors++;
        if ({idx_valid, idx, grant_cnt} !== exp || idx_valid !== 1'b0 || idx !== 5'd2) begin
            miscompares++;
            $display("FAIL en_drop_accept: got valid=%b idx=%0d want valid=0 idx=2", idx_valid, idx);
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 32'h0000_0004, 1'b1);
            exp = sb.pop_front();
            vectors++;
            if ({idx_valid, idx, grant_cnt} !== exp || grant_cnt !== 16'd1) begin
                miscompares++;
                $display("FAIL ready_when_idle: got valid=%b cnt=%0d want valid=0 cnt=1", idx_valid, grant_cnt);
            end
        end
        apply(1'b1, 32'h0000_0004, 1'b0);
        exp = sb.pop_front();
        vectors++;
        if ({idx_valid, idx, grant_cnt} !== exp || idx_valid !== 1'b1 || idx !== 5'd2) begin
            miscompares++;
            $display("FAIL en_regrant: got valid=%b idx=%0d want valid=1 idx=2", idx_valid, idx);
        end
    endtask

    task automatic test_saturate();
        logic [21:0] exp;
        do_reset();
        for (int i = 0; i < 65540; i++) begin
            apply(1'b1, 32'h0000_0001, 1'b1);
            exp = sb.pop_front();
            vectors++;
            if ({idx_valid, idx, grant_cnt} !== exp) begin
                miscompares++;
                $display("FAIL saturate cyc%0d: got cnt=%0d want %h", i, grant_cnt, exp);
            end
        end
        vectors++;
        if (grant_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL saturate_final: got cnt=%h want ffff", grant_cnt);
        end
    endtask

    task automatic test_async_reset();
        logic [21:0] exp;
        do_reset();
        apply(1'b1, 32'h0000_0200, 1'b0);
        exp = sb.pop_front();
        vectors++;
        if ({idx_valid, idx, grant_cnt} !== exp || idx !== 5'd9) begin
            miscompares++;
            $display("FAIL arst_setup: got idx=%0d want 9", idx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({idx_valid, idx, grant_cnt} !== 22'd0) begin
            miscompares++;
            $display("FAIL arst_immediate: got valid=%b idx=%0d cnt=%0d want 0", idx_valid, idx, grant_cnt);
        end
        #2;
        rst_n = 1'b1;
        model_reset();
        apply(1'b1, 32'h0000_0600, 1'b1);
        exp = sb.pop_front();
        vectors++;
        if ({idx_valid, idx, grant_cnt} !== exp || idx !== 5'd9) begin
            miscompares++;
            $display("FAIL arst_ptr0: got valid=%b idx=%0d want idx=9", idx_valid, idx);
        end
    endtask

    task automatic test_random();
        logic [21:0] exp;
        logic [31:0] r;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            r = $urandom() & $urandom() & $urandom();
            if ($urandom_range(0, 7) == 0) r = 32'd0;
            apply($urandom_range(0, 5) != 0, r, $urandom_range(0, 2) != 0);
            exp = sb.pop_front();
            vectors++;
            if ({idx_valid, idx, grant_cnt} !== exp) begin
                miscompares++;
                $display("FAIL random cyc%0d: got %h want %h", i, {idx_valid, idx, grant_cnt}, exp);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        en          = 1'b0;
        req         = 32'd0;
        idx_ready   = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_single();
        test_wrap();
        test_hold();
        test_en_drop();
        test_async_reset();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
